// File: rtl/uart_pkg.sv
// Shared UART constants and helpers.
//   CLK_HZ         : system clock frequency
//   DEF_BAUD       : default line rate
//   DEF_OVERSAMPLE : default oversample ticks per bit
//   calc_div()     : rounded prescaler divisor for a clock/baud/oversample triple
package uart_pkg;

  localparam int unsigned CLK_HZ         = 50_000_000;
  localparam int unsigned DEF_BAUD       = 115_200;
  localparam int unsigned DEF_OVERSAMPLE = 16;

  // round(clk_hz / (baud * os)); a zero denominator yields 0 (tick every cycle)
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    longint unsigned den;
    longint unsigned quo;
    den = longint'(baud) * longint'(os);
    if (den == 0) return 0;
    quo = (longint'(clk_hz) + den / 2) / den;
    return 32'(quo);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Runtime-programmable prescaler producing the oversample tick.
//   clk, s_reset : clock and synchronous active-high reset
//   enable       : count enable (counter holds when low)
//   resync       : restart the period from zero
//   divisor      : new divisor value, captured on div_load
//   div_load     : capture divisor into the shadow register
//   os_tick      : registered one-cycle pulse every max(active_div,1) enabled cycles
//   wrap_step    : unregistered strobe, high in the cycle whose edge raises os_tick
module tick_prescaler #(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 27
) (
  input  logic             clk,
  input  logic             s_reset,
  input  logic             enable,
  input  logic             resync,
  input  logic [DIV_W-1:0] divisor,
  input  logic             div_load,
  output logic             os_tick,
  output logic             wrap_step
);

  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] active_div;
  logic [DIV_W-1:0] shadow_div;
  logic             pending;
  logic [DIV_W-1:0] last;
  logic             wrap;

  // Divisors 0 and 1 both mean a period of one cycle.
  always_comb begin
    last = '0;
    if (active_div > DIV_W'(1)) last = active_div - DIV_W'(1);
  end

  // >= rather than == so a divisor shrunk while idle can never strand cnt above the wrap point.
  assign wrap      = (cnt >= last);
  assign wrap_step = !s_reset && !resync && enable && wrap;

  always_ff @(posedge clk) begin
    if (s_reset) begin
      cnt        <= '0;
      os_tick    <= 1'b0;
      active_div <= DEF_DIV;
      shadow_div <= DEF_DIV;
      pending    <= 1'b0;
    end else if (resync || !enable) begin
      // No period is in flight from the output's point of view, so updates take effect at once.
      if (resync) cnt <= '0;
      os_tick <= 1'b0;
      pending <= 1'b0;
      if (div_load) begin
        shadow_div <= divisor;
        active_div <= divisor;
      end else if (pending) begin
        active_div <= shadow_div;
      end
    end else begin
      if (wrap) begin
        cnt     <= '0;
        os_tick <= 1'b1;
        if (pending) begin
          active_div <= shadow_div;
          pending    <= 1'b0;
        end
      end else begin
        cnt     <= cnt + DIV_W'(1);
        os_tick <= 1'b0;
      end
      // A load landing on the wrap edge re-arms pending and waits for the next wrap.
      if (div_load) begin
        shadow_div <= divisor;
        pending    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// Baud-rate tick generator: oversample, bit and mid-bit ticks.
//   clk, s_reset : clock and synchronous active-high reset
//   enable       : count enable (all counters hold when low)
//   resync       : restart prescaler and bit phase (start-bit alignment)
//   divisor      : new prescaler divisor, captured on div_load
//   div_load     : load pulse for divisor
//   os_tick      : one-cycle pulse per oversample period
//   bit_tick     : one-cycle pulse when the oversample phase wraps to 0
//   mid_tick     : one-cycle pulse when the phase reaches OVERSAMPLE/2
//   os_phase     : current oversample index within the bit
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned OVERSAMPLE  = DEF_OVERSAMPLE,
  parameter int unsigned DEFAULT_DIV = calc_div(CLK_HZ, DEF_BAUD, DEF_OVERSAMPLE),
  localparam int unsigned PH_W       = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1
) (
  input  logic             clk,
  input  logic             s_reset,
  input  logic             enable,
  input  logic             resync,
  input  logic [DIV_W-1:0] divisor,
  input  logic             div_load,
  output logic             os_tick,
  output logic             bit_tick,
  output logic             mid_tick,
  output logic [PH_W-1:0]  os_phase
);

  localparam logic [PH_W-1:0] LAST_PH = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0] MID_PH  = PH_W'(OVERSAMPLE / 2);

  logic            wrap_step;
  logic [PH_W-1:0] phase_next;

  tick_prescaler #(
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_prescaler (
    .clk       (clk),
    .s_reset   (s_reset),
    .enable    (enable),
    .resync    (resync),
    .divisor   (divisor),
    .div_load  (div_load),
    .os_tick   (os_tick),
    .wrap_step (wrap_step)
  );

  always_comb begin
    phase_next = os_phase + PH_W'(1);
    if (os_phase == LAST_PH) phase_next = '0;
  end

  // Phase advances on the same edge that raises os_tick, so bit/mid ticks align with it.
  always_ff @(posedge clk) begin
    if (s_reset || resync) begin
      os_phase <= '0;
      bit_tick <= 1'b0;
      mid_tick <= 1'b0;
    end else if (wrap_step) begin
      os_phase <= phase_next;
      bit_tick <= (phase_next == '0);
      mid_tick <= (phase_next == MID_PH);
    end else begin
      bit_tick <= 1'b0;
      mid_tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_baud_tick_gen.sv
module tb_baud_tick_gen;

  localparam int unsigned DIV_W = 16;
  localparam int unsigned OS    = 4;
  localparam int unsigned DEF   = 4;

  logic             clk = 1'b0;
  logic             s_reset;
  logic             enable;
  logic             resync;
  logic [DIV_W-1:0] divisor;
  logic             div_load;
  logic             os_tick;
  logic             bit_tick;
  logic             mid_tick;
  logic [1:0]       os_phase;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  baud_tick_gen #(
    .DIV_W       (DIV_W),
    .OVERSAMPLE  (OS),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk      (clk),
    .s_reset  (s_reset),
    .enable   (enable),
    .resync   (resync),
    .divisor  (divisor),
    .div_load (div_load),
    .os_tick  (os_tick),
    .bit_tick (bit_tick),
    .mid_tick (mid_tick),
    .os_phase (os_phase)
  );

  // One rising edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT just out of reset; the next rising edge is edge 1.
  task automatic do_reset();
    s_reset  = 1'b1;
    enable   = 1'b0;
    resync   = 1'b0;
    div_load = 1'b0;
    divisor  = '0;
    tick();
    s_reset  = 1'b0;
  endtask

  task automatic test_reset();
    s_reset  = 1'b1;
    enable   = 1'b1;
    resync   = 1'b0;
    div_load = 1'b0;
    divisor  = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({os_tick, bit_tick, mid_tick, os_phase} !== 5'b0) begin
        errors++;
        $display("FAIL reset cycle %0d: got os=%b bit=%b mid=%b ph=%0d expected all 0",
                 i, os_tick, bit_tick, mid_tick, os_phase);
      end
    end
    s_reset = 1'b0;
  endtask

  task automatic test_basic();
    logic exp_os, exp_bit, exp_mid;
    logic [1:0] exp_ph;
    do_reset();
    enable = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      tick();
      exp_os  = (e % 4 == 0);
      exp_mid = (e == 8) || (e == 24);
      exp_bit = (e == 16) || (e == 32);
      exp_ph  = 2'((e / 4) % 4);
      checks += 4;
      if (os_tick !== exp_os) begin errors++;
        $display("FAIL basic os_tick edge %0d: got %b expected %b", e, os_tick, exp_os); end
      if (mid_tick !== exp_mid) begin errors++;
        $display("FAIL basic mid_tick edge %0d: got %b expected %b", e, mid_tick, exp_mid); end
      if (bit_tick !== exp_bit) begin errors++;
        $display("FAIL basic bit_tick edge %0d: got %b expected %b", e, bit_tick, exp_bit); end
      if (os_phase !== exp_ph) begin errors++;
        $display("FAIL basic os_phase edge %0d: got %0d expected %0d", e, os_phase, exp_ph); end
    end
  endtask

  task automatic test_div_load();
    logic exp_os, exp_bit, exp_mid;
    do_reset();
    enable  = 1'b1;
    divisor = 16'd6;
    for (int e = 1; e <= 24; e++) begin
      div_load = (e == 5);
      tick();
      exp_os  = (e == 4) || (e == 8) || (e == 14) || (e == 20);
      exp_mid = (e == 8);
      exp_bit = (e == 20);
      checks += 3;
      if (os_tick !== exp_os) begin errors++;
        $display("FAIL divload os_tick edge %0d: got %b expected %b", e, os_tick, exp_os); end
      if (mid_tick !== exp_mid) begin errors++;
        $display("FAIL divload mid_tick edge %0d: got %b expected %b", e, mid_tick, exp_mid); end
      if (bit_tick !== exp_bit) begin errors++;
        $display("FAIL divload bit_tick edge %0d: got %b expected %b", e, bit_tick, exp_bit); end
    end
    div_load = 1'b0;
  endtask

  task automatic test_resync();
    logic exp_os, exp_bit, exp_mid;
    logic [1:0] exp_ph;
    do_reset();
    enable = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      resync = (e == 10);
      tick();
      if (e < 10) begin
        exp_os = (e % 4 == 0);
        exp_ph = 2'(e / 4);
      end else begin
        exp_os = (e > 10) && ((e - 10) % 4 == 0);
        exp_ph = 2'(((e - 10) / 4) % 4);
      end
      exp_mid = (e == 8) || (e == 18);
      exp_bit = (e == 26);
      checks += 4;
      if (os_tick !== exp_os) begin errors++;
        $display("FAIL resync os_tick edge %0d: got %b expected %b", e, os_tick, exp_os); end
      if (mid_tick !== exp_mid) begin errors++;
        $display("FAIL resync mid_tick edge %0d: got %b expected %b", e, mid_tick, exp_mid); end
      if (bit_tick !== exp_bit) begin errors++;
        $display("FAIL resync bit_tick edge %0d: got %b expected %b", e, bit_tick, exp_bit); end
      if (os_phase !== exp_ph) begin errors++;
        $display("FAIL resync os_phase edge %0d: got %0d expected %0d", e, os_phase, exp_ph); end
    end
    resync = 1'b0;
  endtask

  task automatic test_enable_gap();
    logic exp_os, exp_mid;
    logic [1:0] exp_ph;
    do_reset();
    for (int e = 1; e <= 16; e++) begin
      enable = !(e >= 6 && e <= 9);
      tick();
      exp_os  = (e == 4) || (e == 12) || (e == 16);
      exp_mid = (e == 12);
      exp_ph  = (e < 4) ? 2'd0 : (e < 12) ? 2'd1 : (e < 16) ? 2'd2 : 2'd3;
      checks += 3;
      if (os_tick !== exp_os) begin errors++;
        $display("FAIL gap os_tick edge %0d: got %b expected %b", e, os_tick, exp_os); end
      if (mid_tick !== exp_mid) begin errors++;
        $display("FAIL gap mid_tick edge %0d: got %b expected %b", e, mid_tick, exp_mid); end
      if (os_phase !== exp_ph) begin errors++;
        $display("FAIL gap os_phase edge %0d: got %0d expected %0d", e, os_phase, exp_ph); end
    end
  endtask

  task automatic test_div_zero();
    logic exp_bit, exp_mid;
    logic [1:0] exp_ph;
    do_reset();
    divisor  = 16'd0;
    div_load = 1'b1;
    tick();
    div_load = 1'b0;
    tick();
    checks++;
    if (os_tick !== 1'b0) begin errors++;
      $display("FAIL divzero os_tick while disabled: got %b expected 0", os_tick); end
    enable = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      exp_ph  = 2'(e % 4);
      exp_bit = (e % 4 == 0);
      exp_mid = (e % 4 == 2);
      checks += 4;
      if (os_tick !== 1'b1) begin errors++;
        $display("FAIL divzero os_tick edge %0d: got %b expected 1", e, os_tick); end
      if (bit_tick !== exp_bit) begin errors++;
        $display("FAIL divzero bit_tick edge %0d: got %b expected %b", e, bit_tick, exp_bit); end
      if (mid_tick !== exp_mid) begin errors++;
        $display("FAIL divzero mid_tick edge %0d: got %b expected %b", e, mid_tick, exp_mid); end
      if (os_phase !== exp_ph) begin errors++;
        $display("FAIL divzero os_phase edge %0d: got %0d expected %0d", e, os_phase, exp_ph); end
    end
  endtask

  task automatic test_reset_with_load();
    logic exp_os;
    do_reset();
    enable = 1'b1;
    for (int e = 1; e <= 6; e++) tick();
    s_reset  = 1'b1;
    div_load = 1'b1;
    divisor  = 16'd9;
    tick();
    s_reset  = 1'b0;
    div_load = 1'b0;
    checks++;
    if ({os_tick, bit_tick, mid_tick, os_phase} !== 5'b0) begin errors++;
      $display("FAIL rstload outputs: got os=%b bit=%b mid=%b ph=%0d expected all 0",
               os_tick, bit_tick, mid_tick, os_phase); end
    for (int e = 1; e <= 12; e++) begin
      tick();
      exp_os = (e % 4 == 0);
      checks++;
      if (os_tick !== exp_os) begin errors++;
        $display("FAIL rstload os_tick edge %0d: got %b expected %b", e, os_tick, exp_os); end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_os;
    do_reset();
    enable  = 1'b1;
    divisor = 16'd2;
    // Load coincides with the wrap at edge 4: period 4 persists until edge 8.
    for (int e = 1; e <= 12; e++) begin
      div_load = (e == 4);
      tick();
      exp_os = (e == 4) || (e == 8) || (e == 10) || (e == 12);
      checks++;
      if (os_tick !== exp_os) begin errors++;
        $display("FAIL b2b os_tick edge %0d: got %b expected %b", e, os_tick, exp_os); end
    end
    // Load together with resync takes effect immediately.
    resync   = 1'b1;
    div_load = 1'b1;
    divisor  = 16'd3;
    tick();
    resync   = 1'b0;
    div_load = 1'b0;
    checks++;
    if ({os_tick, bit_tick, mid_tick, os_phase} !== 5'b0) begin errors++;
      $display("FAIL b2b resync outputs: got os=%b bit=%b mid=%b ph=%0d expected all 0",
               os_tick, bit_tick, mid_tick, os_phase); end
    for (int e = 1; e <= 9; e++) begin
      tick();
      exp_os = (e % 3 == 0);
      checks++;
      if (os_tick !== exp_os) begin errors++;
        $display("FAIL b2b resync os_tick edge %0d: got %b expected %b", e, os_tick, exp_os); end
    end
  endtask

  initial begin
    s_reset  = 1'b1;
    enable   = 1'b0;
    resync   = 1'b0;
    div_load = 1'b0;
    divisor  = '0;
    test_reset();
    test_basic();
    test_div_load();
    test_resync();
    test_enable_gap();
    test_div_zero();
    test_reset_with_load();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
